// File: rtl/broker_pkg.sv
// Shared opcodes, sequencer state encoding and pixel width for the MCU command sequencer.
package broker_pkg;

  localparam int PIXEL_WIDTH = 12;

  localparam logic [7:0] OP_NOP          = 8'h00;
  localparam logic [7:0] OP_SET_ADDRESS  = 8'h01;
  localparam logic [7:0] OP_WRITE_PIXELS = 8'h02;
  localparam logic [7:0] OP_FILL         = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WR_HI,
    ST_WR_LO,
    ST_EMIT,
    ST_FILL_HI,
    ST_FILL_LO,
    ST_FILL_RUN
  } seq_state_e;

endpackage

// File: rtl/frame_address_counter.sv
// Frame write pointer: clear has priority over load, load over increment; wraps at FRAME_PIXELS.
module frame_address_counter #(
  parameter int ADDR_WIDTH   = 17,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_value,
  input  logic                  clear,
  input  logic                  increment,
  output logic [ADDR_WIDTH-1:0] address
);

  logic [ADDR_WIDTH-1:0] address_q, address_d;

  always_comb begin
    address_d = address_q;
    if (clear) begin
      address_d = '0;
    end else if (load) begin
      address_d = load_value;
    end else if (increment) begin
      if (address_q == ADDR_WIDTH'(FRAME_PIXELS - 1)) address_d = '0;
      else                                            address_d = address_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) address_q <= '0;
    else        address_q <= address_d;
  end

  assign address = address_q;

endmodule

// File: rtl/mcu_command_sequencer.sv
// Decodes the tagged MCU byte stream into framebuffer pixel writes, including full-frame fills.
module mcu_command_sequencer
  import broker_pkg::*;
#(
  parameter int ADDR_WIDTH   = 17,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic                   system_clock,
  input  logic                   system_reset_n,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  input  logic [7:0]             byte_data,
  input  logic                   byte_is_command,
  output logic                   write_valid,
  input  logic                   write_ready,
  output logic [ADDR_WIDTH-1:0]  write_address,
  output logic [PIXEL_WIDTH-1:0] write_pixel,
  output logic [ADDR_WIDTH-1:0]  current_address,
  output logic                   busy,
  output logic [7:0]             error_count
);

  seq_state_e             state_q, state_d;
  logic [1:0]             addr_cnt_q, addr_cnt_d;
  logic [31:0]            addr_sr_q, addr_sr_d;
  logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
  logic [7:0]             err_q;
  logic                   err_inc;
  logic                   byte_accept;
  logic                   ptr_load, ptr_clear, ptr_inc;
  logic [ADDR_WIDTH-1:0]  ptr;
  logic [31:0]            addr_full;
  logic                   last_pixel;

  assign byte_ready  = !(state_q == ST_EMIT || state_q == ST_FILL_RUN);
  assign byte_accept = byte_valid && byte_ready;
  assign addr_full   = {addr_sr_q[23:0], byte_data};
  assign last_pixel  = (ptr == ADDR_WIDTH'(FRAME_PIXELS - 1));

  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    addr_sr_d  = addr_sr_q;
    pixel_d    = pixel_q;
    err_inc    = 1'b0;
    ptr_load   = 1'b0;
    ptr_clear  = 1'b0;
    ptr_inc    = 1'b0;

    // A command byte always wins: any half-collected address or pixel is abandoned.
    if (byte_accept && byte_is_command) begin
      addr_cnt_d = '0;
      case (byte_data)
        OP_NOP:          state_d = ST_IDLE;
        OP_SET_ADDRESS:  state_d = ST_ADDR;
        OP_WRITE_PIXELS: state_d = ST_WR_HI;
        OP_FILL:         state_d = ST_FILL_HI;
        default: begin
          state_d = ST_IDLE;
          err_inc = 1'b1;
        end
      endcase
    end else if (byte_accept) begin
      case (state_q)
        ST_IDLE: err_inc = 1'b1;
        ST_ADDR: begin
          addr_sr_d  = addr_full;
          addr_cnt_d = addr_cnt_q + 2'd1;
          if (addr_cnt_q == 2'd3) begin
            state_d = ST_IDLE;
            if (addr_full >= 32'(FRAME_PIXELS)) begin
              ptr_clear = 1'b1;
              err_inc   = 1'b1;
            end else begin
              ptr_load = 1'b1;
            end
          end
        end
        ST_WR_HI, ST_FILL_HI: begin
          pixel_d[PIXEL_WIDTH-1:4] = byte_data;
          state_d = (state_q == ST_WR_HI) ? ST_WR_LO : ST_FILL_LO;
        end
        ST_WR_LO: begin
          pixel_d[3:0] = byte_data[3:0];
          state_d      = ST_EMIT;
        end
        ST_FILL_LO: begin
          pixel_d[3:0] = byte_data[3:0];
          ptr_clear    = 1'b1;
          state_d      = ST_FILL_RUN;
        end
        default: ;
      endcase
    end else if (write_ready) begin
      case (state_q)
        ST_EMIT: begin
          ptr_inc = 1'b1;
          state_d = ST_WR_HI;
        end
        ST_FILL_RUN: begin
          ptr_inc = 1'b1;
          if (last_pixel) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q    <= ST_IDLE;
      addr_cnt_q <= '0;
      addr_sr_q  <= '0;
      pixel_q    <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      addr_sr_q  <= addr_sr_d;
      pixel_q    <= pixel_d;
      if (err_inc && err_q != '1) err_q <= err_q + 8'd1;
    end
  end

  frame_address_counter #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .FRAME_PIXELS (FRAME_PIXELS)
  ) u_frame_address_counter (
    .clk        (system_clock),
    .rst_n      (system_reset_n),
    .load       (ptr_load),
    .load_value (addr_full[ADDR_WIDTH-1:0]),
    .clear      (ptr_clear),
    .increment  (ptr_inc),
    .address    (ptr)
  );

  assign write_valid     = (state_q == ST_EMIT) || (state_q == ST_FILL_RUN);
  assign write_address   = ptr;
  assign write_pixel     = pixel_q;
  assign current_address = ptr;
  assign busy            = (state_q != ST_IDLE);
  assign error_count     = err_q;

endmodule

// File: tb/tb_mcu_command_sequencer.sv
// Scoreboard bench for mcu_command_sequencer: expected writes queued at stimulus, popped on handshake.
module tb_mcu_command_sequencer;

  localparam int AW = 17;
  localparam int FP = 76800;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [7:0]    byte_data = '0;
  logic          byte_is_command = 1'b0;
  logic          write_valid;
  logic          write_ready = 1'b0;
  logic [AW-1:0] write_address;
  logic [11:0]   write_pixel;
  logic [AW-1:0] current_address;
  logic          busy;
  logic [7:0]    error_count;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [11:0]   pix;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned writes_seen = 0;

  always #5 clk = ~clk;

  mcu_command_sequencer #(
    .ADDR_WIDTH   (AW),
    .FRAME_PIXELS (FP)
  ) dut (
    .system_clock    (clk),
    .system_reset_n  (rst_n),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .byte_data       (byte_data),
    .byte_is_command (byte_is_command),
    .write_valid     (write_valid),
    .write_ready     (write_ready),
    .write_address   (write_address),
    .write_pixel     (write_pixel),
    .current_address (current_address),
    .busy            (busy),
    .error_count     (error_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on negedge; the monitor samples 2 time units later, well before the next posedge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && write_valid && write_ready) begin
      writes_seen++;
      check_eq("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check_eq("wr_addr", 32'(write_address), 32'(e.addr));
        check_eq("wr_pixel", 32'(write_pixel), 32'(e.pix));
      end
    end
  end

  task automatic send_byte(input logic cmd, input logic [7:0] d);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!byte_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check_eq("byte_ready_timeout", 32'(byte_ready), 32'd1);
    byte_valid      = 1'b1;
    byte_data       = d;
    byte_is_command = cmd;
    @(negedge clk);
    byte_valid      = 1'b0;
    byte_is_command = 1'b0;
  endtask

  task automatic set_addr(input logic [31:0] a);
    send_byte(1'b1, 8'h01);
    for (int i = 3; i >= 0; i--) send_byte(1'b0, a[8*i +: 8]);
  endtask

  task automatic idle_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned base;
    int unsigned n;
    wr_t w;

    // Reset values
    #2;
    check_eq("rst_byte_ready", 32'(byte_ready), 32'd1);
    check_eq("rst_write_valid", 32'(write_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err", 32'(error_count), 32'd0);
    check_eq("rst_addr", 32'(current_address), 32'd0);
    check_eq("rst_pixel", 32'(write_pixel), 32'd0);
    idle_cycles(3);
    rst_n = 1'b1;

    // 1: SET_ADDRESS 256
    set_addr(32'h0000_0100);
    #1;
    check_eq("t1_addr", 32'(current_address), 32'd256);
    check_eq("t1_err", 32'(error_count), 32'd0);
    check_eq("t1_busy", 32'(busy), 32'd0);

    // 2: WRITE_PIXELS, two pairs
    write_ready = 1'b1;
    send_byte(1'b1, 8'h02);
    send_byte(1'b0, 8'hAB);
    w.addr = AW'(256); w.pix = 12'hABC; exp_q.push_back(w);
    send_byte(1'b0, 8'hFC);
    #1;
    check_eq("t2_valid_latency", 32'(write_valid), 32'd1);
    check_eq("t2_byte_ready_emit", 32'(byte_ready), 32'd0);
    @(negedge clk); #1;
    check_eq("t2_ptr_257", 32'(current_address), 32'd257);
    check_eq("t2_valid_drop", 32'(write_valid), 32'd0);
    check_eq("t2_busy_wr_hi", 32'(busy), 32'd1);
    send_byte(1'b0, 8'h3C);
    w.addr = AW'(257); w.pix = 12'h3C9; exp_q.push_back(w);
    send_byte(1'b0, 8'h59);
    idle_cycles(2); #3;
    check_eq("t2_ptr_258", 32'(current_address), 32'd258);
    check_eq("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3: last pixel with stalled write_ready, then wrap
    write_ready = 1'b0;
    set_addr(32'd76799);
    send_byte(1'b1, 8'h02);
    send_byte(1'b0, 8'h5A);
    w.addr = AW'(76799); w.pix = 12'h5A7; exp_q.push_back(w);
    send_byte(1'b0, 8'h17);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("t3_stall_valid", 32'(write_valid), 32'd1);
      check_eq("t3_stall_addr", 32'(write_address), 32'd76799);
      check_eq("t3_stall_pixel", 32'(write_pixel), 32'h5A7);
      check_eq("t3_stall_byte_ready", 32'(byte_ready), 32'd0);
      @(negedge clk);
    end
    write_ready = 1'b1;
    @(negedge clk);
    write_ready = 1'b0;
    #3;
    check_eq("t3_wrap", 32'(current_address), 32'd0);
    check_eq("t3_valid_drop", 32'(write_valid), 32'd0);
    check_eq("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: full-frame fill
    write_ready = 1'b1;
    for (int i = 0; i < FP; i++) begin
      w.addr = AW'(i); w.pix = 12'h123; exp_q.push_back(w);
    end
    base = writes_seen;
    send_byte(1'b1, 8'h03);
    send_byte(1'b0, 8'h12);
    send_byte(1'b0, 8'h03);
    #1;
    check_eq("t4_fill_byte_ready", 32'(byte_ready), 32'd0);
    n = 0;
    while (busy && n < 80000) begin
      @(negedge clk);
      n++;
    end
    check_eq("t4_fill_done", 32'(busy), 32'd0);
    #3;
    check_eq("t4_fill_count", writes_seen - base, 32'(FP));
    check_eq("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("t4_ptr", 32'(current_address), 32'd0);
    check_eq("t4_valid", 32'(write_valid), 32'd0);

    // 4b: reset in the middle of a repeat fill
    for (int i = 0; i < 1200; i++) begin
      w.addr = AW'(i); w.pix = 12'h456; exp_q.push_back(w);
    end
    base = writes_seen;
    send_byte(1'b1, 8'h03);
    send_byte(1'b0, 8'h45);
    send_byte(1'b0, 8'h06);
    n = 0;
    while (writes_seen - base < 1000 && n < 5000) begin
      @(negedge clk);
      #3;
      n++;
    end
    check_eq("t4b_reached_1000", writes_seen - base, 32'd1000);
    rst_n = 1'b0;
    #1;
    check_eq("t4b_async_valid", 32'(write_valid), 32'd0);
    check_eq("t4b_async_busy", 32'(busy), 32'd0);
    check_eq("t4b_async_ptr", 32'(current_address), 32'd0);
    exp_q.delete();
    base = writes_seen;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(20);
    #3;
    check_eq("t4b_no_resume", writes_seen - base, 32'd0);
    check_eq("t4b_idle", 32'(busy), 32'd0);
    check_eq("t4b_byte_ready", 32'(byte_ready), 32'd1);

    // 5: protocol errors
    set_addr(32'd5);
    #1;
    check_eq("t5_pre_ptr", 32'(current_address), 32'd5);
    send_byte(1'b0, 8'h55);
    #1;
    check_eq("t5_err_data_idle", 32'(error_count), 32'd1);
    send_byte(1'b1, 8'h7F);
    #1;
    check_eq("t5_err_bad_op", 32'(error_count), 32'd2);
    check_eq("t5_busy_bad_op", 32'(busy), 32'd0);
    set_addr(32'h0002_0000);
    #1;
    check_eq("t5_err_range", 32'(error_count), 32'd3);
    check_eq("t5_ptr_zero", 32'(current_address), 32'd0);
    send_byte(1'b1, 8'h00);
    #1;
    check_eq("t5_nop_err", 32'(error_count), 32'd3);
    check_eq("t5_nop_busy", 32'(busy), 32'd0);

    // 6: command aborts half pixel
    send_byte(1'b1, 8'h02);
    send_byte(1'b0, 8'hAB);
    base = writes_seen;
    set_addr(32'h0000_0010);
    idle_cycles(3);
    #3;
    check_eq("t6_no_write", writes_seen - base, 32'd0);
    check_eq("t6_ptr", 32'(current_address), 32'd16);
    check_eq("t6_busy", 32'(busy), 32'd0);
    send_byte(1'b1, 8'h02);
    send_byte(1'b0, 8'h9E);
    w.addr = AW'(16); w.pix = 12'h9E1; exp_q.push_back(w);
    send_byte(1'b0, 8'h41);
    idle_cycles(3);
    #3;
    check_eq("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    check_eq("t6_ptr_after", 32'(current_address), 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
